// File: rtl/pipeline_ctrl.sv
// Stall/bubble sequencer for the 5-stage pipeline: enables are combinational from state and inputs (0-cycle).
// A response advances the pipe in the same cycle. Data miss freezes everything; fetch miss/load-use bubble ID/EX.
module pipeline_ctrl #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_s,
    input  logic [4:0]       id_rs2_s,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd_s,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             idex_bubble,
    output logic [1:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [1:0]    RUN      = 2'd0;
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT - 1);

    // Bit 0 is the fetch-pending flag and bit 1 the data-pending flag, so the
    // encoding is RUN=0, IWAIT=1, DWAIT=2, BOTH=3.
    logic [1:0]       state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] bub_q, bub_d;
    logic             fetch_pend, data_pend;
    logic             freeze, front_stall, load_use, any_resp;

    assign fetch_pend  = state_q[0];
    assign data_pend   = state_q[1];
    assign any_resp    = imem_resp | dmem_resp;
    assign freeze      = data_pend & ~dmem_resp;
    assign front_stall = fetch_pend & ~imem_resp;
    assign load_use    = id_valid & ex_valid & ex_is_load & (ex_rd_s != 5'd0)
                       & ((ex_rd_s == id_rs1_s) | (ex_rd_s == id_rs2_s));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A request is only accepted when not already pending; a response only
    // counts against a flag that was already pending.
    always_comb begin
        state_d    = state_q;
        state_d[0] = fetch_pend ? ~imem_resp : imem_req;
        state_d[1] = data_pend  ? ~dmem_resp : dmem_req;
    end

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        idex_bubble = 1'b0;
        if (rst || freeze) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
        end else if (front_stall || load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (state_q == RUN || any_resp) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + WW'(1);
        end
        err_d   = err_q | (wait_q == WAIT_MAX);
        stall_d = (!pc_we && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
        bub_d   = (idex_bubble && bub_q != '1) ? bub_q + CNT_W'(1) : bub_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            bub_q   <= '0;
        end else begin
            wait_q  <= wait_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            bub_q   <= bub_d;
        end
    end

    assign state      = state_q;
    assign err        = err_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bub_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboarded bench for pipeline_ctrl: directed test-plan scenarios followed by randomized traffic.
module tb_pipeline_ctrl;
    localparam int TO  = 8;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic imem_req = 0, imem_resp = 0, dmem_req = 0, dmem_resp = 0;
    logic id_valid = 0, ex_valid = 0, ex_is_load = 0;
    logic [4:0] id_rs1_s = 0, id_rs2_s = 0, ex_rd_s = 0;
    logic pc_we, ifid_we, idex_we, exmem_we, memwb_we, idex_bubble, err;
    logic [1:0] state;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .id_valid(id_valid), .id_rs1_s(id_rs1_s), .id_rs2_s(id_rs2_s),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd_s(ex_rd_s),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
        .exmem_we(exmem_we), .memwb_we(memwb_we), .idex_bubble(idex_bubble),
        .state(state), .err(err), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        logic [4:0]    en;
        logic          bub;
        logic [1:0]    st;
        logic          er;
        logic [CW-1:0] sc;
        logic [CW-1:0] bc;
    } exp_t;

    exp_t sbq[$];
    int n_chk = 0;
    int n_pass = 0;

    // Reference model: outstanding-miss booleans and plain integer counters.
    bit m_ifetch, m_data, m_err;
    int m_wait, m_sc, m_bc;

    // Stimulus for the next cycle; tick() applies it and then clears it.
    bit s_ireq, s_iresp, s_dreq, s_dresp, s_idv, s_exv, s_exl;
    logic [4:0] s_rs1, s_rs2, s_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        n_chk++;
        if (act === ex) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
    endtask

    function automatic logic [31:0] en_vec();
        return 32'({pc_we, ifid_we, idex_we, exmem_we, memwb_we});
    endfunction

    task automatic model_clear();
        m_ifetch = 0; m_data = 0; m_err = 0;
        m_wait = 0; m_sc = 0; m_bc = 0;
    endtask

    task automatic tick();
        exp_t e;
        bit frz, hazard, stl;
        @(posedge clk);
        #1;
        imem_req = s_ireq;  imem_resp = s_iresp;
        dmem_req = s_dreq;  dmem_resp = s_dresp;
        id_valid = s_idv;   id_rs1_s = s_rs1;  id_rs2_s = s_rs2;
        ex_valid = s_exv;   ex_is_load = s_exl; ex_rd_s = s_rd;

        frz    = m_data && !s_dresp;
        hazard = s_idv && s_exv && s_exl && s_rd != 0 && (s_rd == s_rs1 || s_rd == s_rs2);
        stl    = !frz && ((m_ifetch && !s_iresp) || hazard);
        e.en   = frz ? 5'b00000 : (stl ? 5'b00111 : 5'b11111);
        e.bub  = stl;
        e.st   = (m_ifetch && m_data) ? 2'd3 : m_data ? 2'd2 : m_ifetch ? 2'd1 : 2'd0;
        e.er   = m_err;
        e.sc   = CW'(m_sc);
        e.bc   = CW'(m_bc);
        sbq.push_back(e);

        if (e.en[4] == 1'b0) m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
        if (stl) m_bc = (m_bc < SAT) ? m_bc + 1 : SAT;
        if (m_wait == TO - 1) m_err = 1;
        if (!m_ifetch && !m_data) m_wait = 0;
        else if (s_iresp || s_dresp) m_wait = 0;
        else if (m_wait < TO - 1) m_wait++;
        m_ifetch = m_ifetch ? !s_iresp : s_ireq;
        m_data   = m_data ? !s_dresp : s_dreq;

        s_ireq = 0; s_iresp = 0; s_dreq = 0; s_dresp = 0;
        s_idv = 0; s_exv = 0; s_exl = 0; s_rs1 = 0; s_rs2 = 0; s_rd = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async_en", en_vec(), 32'd0);
        chk("rst_async_bubble", 32'(idex_bubble), 32'd0);
        chk("rst_async_stall_cnt", 32'(stall_cnt), 32'd0);
        imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
        id_valid = 0; ex_valid = 0; ex_is_load = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        #2;
        chk("post_rst_en", en_vec(), 32'h1f);
        chk("post_rst_state", 32'(state), 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("enables", en_vec(), 32'(e.en));
                chk("idex_bubble", 32'(idex_bubble), 32'(e.bub));
                chk("state", 32'(state), 32'(e.st));
                chk("err", 32'(err), 32'(e.er));
                chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
                chk("bubble_cnt", 32'(bubble_cnt), 32'(e.bc));
            end
        end
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        model_clear();
        s_ireq = 0; s_iresp = 0; s_dreq = 0; s_dresp = 0;
        s_idv = 0; s_exv = 0; s_exl = 0; s_rs1 = 0; s_rs2 = 0; s_rd = 0;
        #2;
        chk("init_rst_en", en_vec(), 32'd0);
        chk("init_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk("init_release_en", en_vec(), 32'h1f);
        chk("init_release_state", 32'(state), 32'd0);
        repeat (3) tick();

        // Fetch miss: request in cycle 0, response in cycle 4.
        do_reset();
        s_ireq = 1; tick();
        repeat (3) tick();
        s_iresp = 1; tick();
        #1 chk("fetch_resp_pc_we", 32'(pc_we), 32'd1);
        tick();
        #1 chk("fetch_stall_total", 32'(stall_cnt), 32'd3);
        chk("fetch_bubble_total", 32'(bubble_cnt), 32'd3);

        // Data miss overlapping a fetch miss.
        do_reset();
        s_ireq = 1; tick();
        s_dreq = 1; tick();
        #1 chk("overlap_state_c1", 32'(state), 32'd1);
        s_iresp = 1; tick();
        #1 chk("overlap_state_c2", 32'(state), 32'd3);
        chk("overlap_freeze_c2", en_vec(), 32'd0);
        tick();
        #1 chk("overlap_state_c3", 32'(state), 32'd2);
        tick();
        #1 chk("overlap_freeze_c4", en_vec(), 32'd0);
        s_dresp = 1; tick();
        #1 chk("overlap_state_c5", 32'(state), 32'd2);
        chk("overlap_adv_c5", en_vec(), 32'h1f);
        tick();
        #1 chk("overlap_state_c6", 32'(state), 32'd0);

        // Load-use with a real destination, then with x0.
        do_reset();
        s_idv = 1; s_rs2 = 5; s_exv = 1; s_exl = 1; s_rd = 5; tick();
        #1 chk("loaduse_bubble", 32'(idex_bubble), 32'd1);
        s_idv = 1; s_rs2 = 5; tick();
        #1 chk("loaduse_after_pc_we", 32'(pc_we), 32'd1);
        s_idv = 1; s_rs1 = 0; s_rs2 = 0; s_exv = 1; s_exl = 1; s_rd = 0; tick();
        #1 chk("loaduse_x0_bubble", 32'(idex_bubble), 32'd0);

        // Reset mid-wait, then a late response that must be ignored.
        do_reset();
        s_dreq = 1; tick();
        tick();
        do_reset();
        s_dresp = 1; tick();
        tick();
        #1 chk("late_resp_state", 32'(state), 32'd0);

        // Watchdog: data miss never answered until after err sets.
        do_reset();
        s_dreq = 1; tick();
        repeat (8) tick();
        #1 chk("wd_err_before", 32'(err), 32'd0);
        tick();
        #1 chk("wd_err_set", 32'(err), 32'd1);
        s_dresp = 1; tick();
        tick();
        #1 chk("wd_err_sticky", 32'(err), 32'd1);

        // Counter saturation under a permanent fetch miss.
        do_reset();
        s_ireq = 1; tick();
        repeat (20) tick();
        #1 chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
        chk("sat_bubble_cnt", 32'(bubble_cnt), 32'd15);

        // Randomized traffic with occasional resets.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int c = 0; c < 120; c++) begin
                s_ireq  = ($urandom_range(0, 3) == 0);
                s_iresp = ($urandom_range(0, 2) == 0);
                s_dreq  = ($urandom_range(0, 4) == 0);
                s_dresp = ($urandom_range(0, 2) == 0);
                s_idv   = ($urandom_range(0, 1) == 1);
                s_exv   = ($urandom_range(0, 1) == 1);
                s_exl   = ($urandom_range(0, 1) == 1);
                s_rs1   = 5'($urandom_range(0, 3));
                s_rs2   = 5'($urandom_range(0, 3));
                s_rd    = 5'($urandom_range(0, 3));
                tick();
            end
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
